// File: rtl/stream_fifo.sv
// stream_fifo: single-clock elastic buffer with valid/ready handshakes on
// both sides. Show-ahead read: the head word is on data_o whenever valid_o=1.
// Depth LEN need not be a power of two; pointers wrap explicitly at LEN-1.
module stream_fifo #(
  parameter int unsigned SIZE = 32,
  parameter int unsigned LEN  = 10
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic            ready_i,
  input  logic [SIZE-1:0] data_i,
  output logic [SIZE-1:0] data_o,
  output logic            valid_o,
  output logic            is_full_o
);

  localparam int unsigned PW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int unsigned CW = $clog2(LEN + 1);

  localparam logic [PW-1:0] PTR_LAST = PW'(LEN - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(LEN);

  logic [SIZE-1:0] mem_q [LEN];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic wr_en;
  logic rd_en;

  // Status flags come only from registered count, never from the handshakes.
  always_comb begin
    valid_o   = (count_q != '0);
    is_full_o = (count_q == CNT_FULL);
    data_o    = valid_o ? mem_q[rd_ptr_q] : '0;
  end

  // Accept decisions, pointer wrap and occupancy update for the next edge.
  always_comb begin
    wr_en    = valid_i & ~is_full_o;
    rd_en    = ready_i & valid_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    end
    if (wr_en && !rd_en) begin
      count_d = count_q + CW'(1);
    end else if (rd_en && !wr_en) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointer and occupancy state; reset discards everything buffered.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care after reset since count gates data_o.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: directed vector table, hand-written corner sequences and a
// randomized phase, all checked against a queue-based reference model.
module tb_stream_fifo;

  localparam int unsigned SIZE = 32;
  localparam int unsigned LEN  = 10;

  logic            clk_i;
  logic            rst_i;
  logic            valid_i;
  logic            ready_i;
  logic [SIZE-1:0] data_i;
  logic [SIZE-1:0] data_o;
  logic            valid_o;
  logic            is_full_o;

  stream_fifo #(.SIZE(SIZE), .LEN(LEN)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_i  (ready_i),
    .data_i   (data_i),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .is_full_o(is_full_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the FIFO contents as an ordered list of words.
  logic [SIZE-1:0] q[$];

  typedef struct {
    logic            v;
    logic            r;
    logic [SIZE-1:0] d;
    logic            ev;
    logic            ef;
    logic [SIZE-1:0] ed;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(logic v, logic r, logic [SIZE-1:0] d,
                              logic ev, logic ef, logic [SIZE-1:0] ed);
    vec_t t;
    t.v = v; t.r = r; t.d = d; t.ev = ev; t.ef = ef; t.ed = ed;
    return t;
  endfunction

  task automatic check(input string name, input logic [SIZE-1:0] act,
                       input logic [SIZE-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Apply the handshake rules to the model for one clock edge.
  task automatic model_edge(input logic v, input logic r, input logic [SIZE-1:0] d);
    int unsigned n;
    bit do_wr, do_rd;
    n     = q.size();
    do_wr = v && (n < LEN);
    do_rd = r && (n > 0);
    if (do_rd) void'(q.pop_front());
    if (do_wr) q.push_back(d);
  endtask

  task automatic check_model(input string name);
    logic [SIZE-1:0] exp_d;
    exp_d = (q.size() > 0) ? q[0] : '0;
    check({name, "_valid"}, SIZE'(valid_o),   SIZE'(q.size() != 0));
    check({name, "_full"},  SIZE'(is_full_o), SIZE'(q.size() == LEN));
    check({name, "_data"},  data_o, exp_d);
  endtask

  // One clock with given inputs, model update, then model comparison.
  task automatic cycle(input logic v, input logic r, input logic [SIZE-1:0] d,
                       input string name);
    valid_i = v;
    ready_i = r;
    data_i  = d;
    @(posedge clk_i);
    model_edge(v, r, d);
    #1;
    check_model(name);
  endtask

  logic [SIZE-1:0] w2[10];
  logic [SIZE-1:0] w4[4];
  int pv, pr;

  initial begin
    w2 = '{32'habcdefaa, 32'hdeaddead, 32'haaaaaaaa, 32'hdddddddd, 32'hdeaddead,
           32'haaaaaaaa, 32'hdddddddd, 32'hdeaddead, 32'haaaaaaaa, 32'hdddddddd};
    w4 = '{32'habcdefaa, 32'hdeaddead, 32'haaaaaaaa, 32'hdddddddd};

    // Directed vectors: inputs for one edge, expected outputs after it.
    tbl[0] = mk(1'b0, 1'b1, '0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 10; k++)
      tbl[1 + k] = mk(1'b1, 1'b0, w2[k], 1'b1, (k == 9), 32'habcdefaa);
    tbl[11] = mk(1'b1, 1'b0, 32'h12345678, 1'b1, 1'b1, 32'habcdefaa);
    tbl[12] = mk(1'b0, 1'b1, '0, 1'b1, 1'b0, 32'hdeaddead);
    tbl[13] = mk(1'b0, 1'b1, '0, 1'b1, 1'b0, 32'haaaaaaaa);
    tbl[14] = mk(1'b0, 1'b1, '0, 1'b1, 1'b0, 32'hdddddddd);
    tbl[15] = mk(1'b0, 1'b1, '0, 1'b1, 1'b0, 32'hdeaddead);
    for (int k = 0; k < 4; k++)
      tbl[16 + k] = mk(1'b1, 1'b0, w4[k], 1'b1, (k == 3), 32'hdeaddead);
    tbl[20] = mk(1'b0, 1'b1, '0, 1'b1, 1'b0, 32'haaaaaaaa);
    tbl[21] = mk(1'b0, 1'b1, '0, 1'b1, 1'b0, 32'hdddddddd);

    // Reset held for 20 cycles.
    rst_i   = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i  = '0;
    repeat (20) @(posedge clk_i);
    #1;
    check("rst_hold_valid", SIZE'(valid_o), '0);
    check("rst_hold_full",  SIZE'(is_full_o), '0);
    check("rst_hold_data",  data_o, '0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("rst_rel_valid", SIZE'(valid_o), '0);
    check("rst_rel_full",  SIZE'(is_full_o), '0);
    check("rst_rel_data",  data_o, '0);

    // Directed fill / refuse / pop / wrap sequence.
    for (int i = 0; i < 22; i++) begin
      valid_i = tbl[i].v;
      ready_i = tbl[i].r;
      data_i  = tbl[i].d;
      @(posedge clk_i);
      #1;
      check($sformatf("vec%0d_valid", i), SIZE'(valid_o), SIZE'(tbl[i].ev));
      check($sformatf("vec%0d_full", i),  SIZE'(is_full_o), SIZE'(tbl[i].ef));
      check($sformatf("vec%0d_data", i),  data_o, tbl[i].ed);
    end

    // Contents remaining after the directed sequence (count 8).
    q = '{32'hdddddddd, 32'hdeaddead, 32'haaaaaaaa, 32'hdddddddd,
          32'habcdefaa, 32'hdeaddead, 32'haaaaaaaa, 32'hdddddddd};

    // Simultaneous push/pop with a partially filled FIFO.
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 1'b1, 32'h5000_0000 + i, $sformatf("both%0d", i));
    check("both_count8", SIZE'(q.size()), 32'd8);

    // Fill to full, then push/pop while full drops the write.
    cycle(1'b1, 1'b0, 32'h6000_0001, "fill9");
    cycle(1'b1, 1'b0, 32'h6000_0002, "fill10");
    check("full_reached", SIZE'(is_full_o), 32'd1);
    cycle(1'b1, 1'b1, 32'h7777_7777, "full_both");
    check("full_both_notfull", SIZE'(is_full_o), '0);

    // Drain with a bounded cycle budget.
    for (int i = 0; i < 20 && valid_o; i++)
      cycle(1'b0, 1'b1, '0, $sformatf("drain%0d", i));
    check("drain_valid", SIZE'(valid_o), '0);
    check("drain_data",  data_o, '0);
    cycle(1'b0, 1'b1, '0, "empty_ready");

    // Asynchronous reset between edges with 5 words stored.
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 1'b0, 32'h8000_0000 + i, $sformatf("pre_rst%0d", i));
    valid_i = 1'b0;
    #3;
    rst_i = 1'b0;
    #1;
    check("async_rst_valid", SIZE'(valid_o), '0);
    check("async_rst_full",  SIZE'(is_full_o), '0);
    check("async_rst_data",  data_o, '0);
    q.delete();
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    cycle(1'b1, 1'b0, 32'h1357_9bdf, "post_rst_wr");
    check("post_rst_head", data_o, 32'h1357_9bdf);

    // Randomized traffic with varying producer/consumer pressure.
    for (int blk = 0; blk < 40; blk++) begin
      case ($urandom_range(0, 3))
        0:       begin pv = 90; pr = 25; end
        1:       begin pv = 25; pr = 90; end
        2:       begin pv = 50; pr = 50; end
        default: begin pv = 95; pr = 95; end
      endcase
      for (int i = 0; i < 50; i++)
        cycle(($urandom_range(0, 99) < pv), ($urandom_range(0, 99) < pr),
              $urandom, $sformatf("rnd%0d_%0d", blk, i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
